// File: rtl/traffic_intersection_pkg.sv
// Shared types, limits and helpers for the N-approach intersection controller.
package traffic_intersection_pkg;

  localparam int unsigned MAX_DIRS  = 8;
  localparam int unsigned CNT_W_DEF = 16;

  typedef logic [CNT_W_DEF-1:0] count_width_t;

  // One-hot so that corrupted state codes are detectable.
  typedef enum logic [3:0] {
    ALL_RED = 4'b0001,
    GREEN   = 4'b0010,
    YELLOW  = 4'b0100,
    FLASH   = 4'b1000
  } intersection_state_t;

  function automatic int unsigned dir_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/traffic_intersection_rr_picker.sv
// Round-robin search: first requesting direction after i_ptr, wrapping back to i_ptr.
module traffic_rr_picker
  import traffic_intersection_pkg::*;
#(
  parameter int unsigned NUM_DIRS = 4,
  parameter int unsigned IDX_W    = dir_idx_w(NUM_DIRS)
) (
  input  logic [IDX_W-1:0]    i_ptr,
  input  logic [NUM_DIRS-1:0] i_req,
  output logic                o_hit_c,
  output logic [IDX_W-1:0]    o_idx_c
);

  always_comb begin
    int unsigned w_cand;
    o_hit_c = 1'b0;
    o_idx_c = '0;
    w_cand  = 0;
    for (int unsigned k = 1; k <= NUM_DIRS; k++) begin
      w_cand = (32'(i_ptr) + k) % NUM_DIRS;
      if (!o_hit_c && i_req[IDX_W'(w_cand)]) begin
        o_hit_c = 1'b1;
        o_idx_c = IDX_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/traffic_intersection.sv
// N-approach round-robin intersection controller with pedestrian walk phase,
// all-red clearance, maintenance flash mode and a sticky illegal-state flag.
module traffic_intersection
  import traffic_intersection_pkg::*;
#(
  parameter int unsigned NUM_DIRS          = 4,
  parameter int unsigned NUM_CYCLES_GREEN  = 10,
  parameter int unsigned NUM_CYCLES_YELLOW = 2,
  parameter int unsigned NUM_CYCLES_ALLRED = 1,
  parameter int unsigned NUM_CYCLES_WALK   = 6,
  parameter int unsigned FLASH_HALF_PERIOD = 4,
  parameter int unsigned CNT_W             = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flash_mode_i,
  input  logic [NUM_DIRS-1:0]         demand_i,
  input  logic [NUM_DIRS-1:0]         ped_req_i,
  output logic [NUM_DIRS-1:0]         red_o,
  output logic [NUM_DIRS-1:0]         yellow_o,
  output logic [NUM_DIRS-1:0]         green_o,
  output logic [NUM_DIRS-1:0]         walk_o,
  output logic [$clog2(NUM_DIRS)-1:0] active_dir_o,
  output logic [NUM_DIRS-1:0]         ped_pending_o,
  output logic                        bad_state_o
);

  localparam int unsigned     DIR_W   = dir_idx_w(NUM_DIRS);
  localparam longint unsigned CNT_LIM = 64'd1 << CNT_W;

  if (NUM_DIRS < 2 || NUM_DIRS > MAX_DIRS) begin : g_err_dirs
    $error("NUM_DIRS must be within 2..8");
  end
  if (NUM_CYCLES_GREEN < 1 || NUM_CYCLES_YELLOW < 1 || NUM_CYCLES_ALLRED < 1 ||
      NUM_CYCLES_WALK < 1 || FLASH_HALF_PERIOD < 1) begin : g_err_zero
    $error("every duration must be at least 1 cycle");
  end
  if (64'(NUM_CYCLES_GREEN) >= CNT_LIM || 64'(NUM_CYCLES_YELLOW) >= CNT_LIM ||
      64'(NUM_CYCLES_ALLRED) >= CNT_LIM || 64'(NUM_CYCLES_WALK) >= CNT_LIM ||
      64'(FLASH_HALF_PERIOD) >= CNT_LIM) begin : g_err_wide
    $error("a duration does not fit in CNT_W bits");
  end
  if (NUM_CYCLES_WALK > NUM_CYCLES_GREEN) begin : g_err_walk
    $error("NUM_CYCLES_WALK must not exceed NUM_CYCLES_GREEN");
  end

  localparam logic [CNT_W-1:0] GREEN_T  = CNT_W'(NUM_CYCLES_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_T = CNT_W'(NUM_CYCLES_YELLOW - 1);
  localparam logic [CNT_W-1:0] ALLRED_T = CNT_W'(NUM_CYCLES_ALLRED - 1);
  localparam logic [CNT_W-1:0] FLASH_T  = CNT_W'(FLASH_HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] WALK_N   = CNT_W'(NUM_CYCLES_WALK);

  intersection_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [DIR_W-1:0]    r_ptr, w_ptr_nxt;
  logic                r_grant, w_grant_nxt;
  logic                r_flash_on, w_flash_on_nxt;
  logic                r_bad, w_bad_nxt;
  logic [NUM_DIRS-1:0] r_ped, w_ped_nxt;
  logic [NUM_DIRS-1:0] r_red, r_yellow, r_green, r_walk;
  logic [NUM_DIRS-1:0] w_red_nxt, w_yellow_nxt, w_green_nxt, w_walk_nxt;
  logic                w_hit;
  logic [DIR_W-1:0]    w_pick;

  traffic_rr_picker #(.NUM_DIRS(NUM_DIRS), .IDX_W(DIR_W)) u_picker (
    .i_ptr   (r_ptr),
    .i_req   (demand_i | r_ped),
    .o_hit_c (w_hit),
    .o_idx_c (w_pick)
  );

  // State register; lamp outputs are registered from the next-state decode.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ALL_RED;
      r_cnt      <= '0;
      r_ptr      <= DIR_W'(NUM_DIRS - 1);
      r_grant    <= 1'b0;
      r_flash_on <= 1'b0;
      r_bad      <= 1'b0;
      r_ped      <= '0;
      r_red      <= '1;
      r_yellow   <= '0;
      r_green    <= '0;
      r_walk     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_flash_on <= w_flash_on_nxt;
      r_bad      <= w_bad_nxt;
      r_ped      <= w_ped_nxt;
      r_red      <= w_red_nxt;
      r_yellow   <= w_yellow_nxt;
      r_green    <= w_green_nxt;
      r_walk     <= w_walk_nxt;
    end
  end

  // Next-state; a count past its terminal value is treated like a bad encoding.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt + CNT_W'(1);
    w_ptr_nxt      = r_ptr;
    w_grant_nxt    = r_grant;
    w_flash_on_nxt = r_flash_on;
    w_bad_nxt      = r_bad;
    w_ped_nxt      = r_ped;
    unique case (r_state)
      ALL_RED: begin
        if (r_cnt > ALLRED_T) begin
          w_state_nxt = ALL_RED;
          w_cnt_nxt   = '0;
          w_bad_nxt   = 1'b1;
        end else if (r_cnt == ALLRED_T) begin
          w_cnt_nxt = r_cnt;
          if (flash_mode_i) begin
            w_state_nxt    = FLASH;
            w_cnt_nxt      = '0;
            w_flash_on_nxt = 1'b1;
          end else if (w_hit) begin
            w_state_nxt       = GREEN;
            w_cnt_nxt         = '0;
            w_ptr_nxt         = w_pick;
            w_grant_nxt       = r_ped[w_pick];
            w_ped_nxt[w_pick] = 1'b0;
          end
        end
      end
      GREEN: begin
        if (r_cnt > GREEN_T) begin
          w_state_nxt = ALL_RED;
          w_cnt_nxt   = '0;
          w_bad_nxt   = 1'b1;
        end else if (flash_mode_i || r_cnt == GREEN_T) begin
          w_state_nxt = YELLOW;
          w_cnt_nxt   = '0;
        end
      end
      YELLOW: begin
        if (r_cnt > YELLOW_T) begin
          w_state_nxt = ALL_RED;
          w_cnt_nxt   = '0;
          w_bad_nxt   = 1'b1;
        end else if (r_cnt == YELLOW_T) begin
          w_state_nxt = ALL_RED;
          w_cnt_nxt   = '0;
        end
      end
      FLASH: begin
        if (r_cnt > FLASH_T) begin
          w_state_nxt = ALL_RED;
          w_cnt_nxt   = '0;
          w_bad_nxt   = 1'b1;
        end else if (!flash_mode_i) begin
          w_state_nxt = ALL_RED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == FLASH_T) begin
          w_cnt_nxt      = '0;
          w_flash_on_nxt = !r_flash_on;
        end
      end
      default: begin
        w_state_nxt = ALL_RED;
        w_cnt_nxt   = '0;
        w_bad_nxt   = 1'b1;
      end
    endcase
    // New button presses win over the grant-time clear.
    w_ped_nxt = w_ped_nxt | ped_req_i;
  end

  // Lamp decode of the upcoming state.
  always_comb begin
    w_red_nxt    = '1;
    w_yellow_nxt = '0;
    w_green_nxt  = '0;
    w_walk_nxt   = '0;
    case (w_state_nxt)
      GREEN: begin
        w_red_nxt[w_ptr_nxt]   = 1'b0;
        w_green_nxt[w_ptr_nxt] = 1'b1;
        w_walk_nxt[w_ptr_nxt]  = w_grant_nxt && (w_cnt_nxt < WALK_N);
      end
      YELLOW: begin
        w_red_nxt[w_ptr_nxt]    = 1'b0;
        w_yellow_nxt[w_ptr_nxt] = 1'b1;
      end
      FLASH: begin
        w_red_nxt    = '0;
        w_yellow_nxt = {NUM_DIRS{w_flash_on_nxt}};
      end
      default: ;
    endcase
  end

  assign red_o         = r_red;
  assign yellow_o      = r_yellow;
  assign green_o       = r_green;
  assign walk_o        = r_walk;
  assign active_dir_o  = r_ptr;
  assign ped_pending_o = r_ped;
  assign bad_state_o   = r_bad;

endmodule

// File: tb/tb_traffic_intersection.sv
// Bench for traffic_intersection: directed scenarios plus random traffic against
// a frame-schedule reference model.
module tb_traffic_intersection;
  import traffic_intersection_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned G   = 10;
  localparam int unsigned Y   = 2;
  localparam int unsigned A   = 1;
  localparam int unsigned W   = 6;
  localparam int unsigned FHP = 4;
  localparam int unsigned DW  = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flash = 1'b0;
  logic [N-1:0]  demand = '0;
  logic [N-1:0]  ped = '0;
  logic [N-1:0]  red_o, yellow_o, green_o, walk_o, ped_pending_o;
  logic [DW-1:0] active_dir_o;
  logic          bad_state_o;

  int total = 0;
  int bad   = 0;

  traffic_intersection #(
    .NUM_DIRS(N), .NUM_CYCLES_GREEN(G), .NUM_CYCLES_YELLOW(Y),
    .NUM_CYCLES_ALLRED(A), .NUM_CYCLES_WALK(W), .FLASH_HALF_PERIOD(FHP), .CNT_W(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flash_mode_i(flash), .demand_i(demand), .ped_req_i(ped),
    .red_o(red_o), .yellow_o(yellow_o), .green_o(green_o), .walk_o(walk_o),
    .active_dir_o(active_dir_o), .ped_pending_o(ped_pending_o), .bad_state_o(bad_state_o)
  );

  always #5 clk = ~clk;

  // Model: each future cycle is a frame (kind 0 all-red, 1 green, 2 yellow, 3 flash).
  typedef struct { int kind; int dir; bit walk; } frame_t;
  frame_t       q[$];
  frame_t       cur;
  int           m_ptr;
  int           flash_k;
  logic [N-1:0] m_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_allred();
    for (int i = 0; i < int'(A); i++) q.push_back('{0, 0, 1'b0});
  endtask

  task automatic model_reset();
    q.delete();
    push_allred();
    cur     = q.pop_front();
    m_ptr   = N - 1;
    m_pend  = '0;
    flash_k = 0;
  endtask

  task automatic model_step();
    int  pick;
    bit  hit;
    if (rst) begin
      model_reset();
      return;
    end
    if (cur.kind == 1 && flash)
      while (q.size() > 0 && q[0].kind == 1) void'(q.pop_front());
    if (cur.kind == 3) begin
      if (flash) flash_k++;
      else begin
        q.delete();
        push_allred();
        cur = q.pop_front();
      end
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (flash) begin
      flash_k = 0;
      cur = '{3, 0, 1'b0};
    end else begin
      hit = 1'b0;
      pick = 0;
      for (int k = 1; k <= int'(N); k++) begin
        int d;
        d = (m_ptr + k) % int'(N);
        if (!hit && (demand[d] || m_pend[d])) begin
          hit = 1'b1;
          pick = d;
        end
      end
      if (hit) begin
        for (int i = 0; i < int'(G); i++) q.push_back('{1, pick, m_pend[pick] && i < int'(W)});
        for (int i = 0; i < int'(Y); i++) q.push_back('{2, pick, 1'b0});
        push_allred();
        m_pend[pick] = 1'b0;
        m_ptr = pick;
        cur = q.pop_front();
      end
    end
    m_pend = m_pend | ped;
  endtask

  task automatic compare_all(input string tag);
    logic [N-1:0] er, ey, eg, ew;
    er = '1; ey = '0; eg = '0; ew = '0;
    case (cur.kind)
      1: begin er[DW'(cur.dir)] = 1'b0; eg[DW'(cur.dir)] = 1'b1; ew[DW'(cur.dir)] = cur.walk; end
      2: begin er[DW'(cur.dir)] = 1'b0; ey[DW'(cur.dir)] = 1'b1; end
      3: begin er = '0; ey = (((flash_k / int'(FHP)) % 2) == 0) ? '1 : '0; end
      default: ;
    endcase
    chk({tag, ".red"},    32'(red_o),         32'(er));
    chk({tag, ".yellow"}, 32'(yellow_o),      32'(ey));
    chk({tag, ".green"},  32'(green_o),       32'(eg));
    chk({tag, ".walk"},   32'(walk_o),        32'(ew));
    chk({tag, ".dir"},    32'(active_dir_o),  32'(m_ptr));
    chk({tag, ".ped"},    32'(ped_pending_o), 32'(m_pend));
    chk({tag, ".bad"},    32'(bad_state_o),   32'(0));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; flash = 1'b0; ped = '0;
    cyc(tag);
    chk({tag, ".rst_red"}, 32'(red_o), 32'(4'b1111));
    chk({tag, ".rst_ped"}, 32'(ped_pending_o), 32'(0));
    chk({tag, ".rst_dir"}, 32'(active_dir_o), 32'(3));
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    // Plan 1: full demand rotates 0,1,2,3,0 with 13-cycle services.
    demand = 4'b1111;
    do_reset("p1");
    cyc("p1");
    chk("p1.first_green", 32'(green_o), 32'(4'b0001));
    run("p1", 60);

    // Plan 2: a single demanding direction is served repeatedly.
    demand = 4'b0100;
    do_reset("p2");
    run("p2", 40);

    // Plan 3: no demand holds all red with pointer at the last direction.
    demand = 4'b0000;
    do_reset("p3");
    run("p3", 100);
    chk("p3.hold_red", 32'(red_o), 32'(4'b1111));

    // Plan 4: pedestrian pulse on dir1 while dir0 is green.
    demand = 4'b0001;
    do_reset("p4");
    run("p4", 3);
    ped = 4'b0010;
    cyc("p4");
    ped = '0;
    chk("p4.latched", 32'(ped_pending_o), 32'(4'b0010));
    run("p4", 30);

    // Plan 5: flash request in dir0 green, then release.
    demand = 4'b1111;
    do_reset("p5");
    run("p5", 3);
    flash = 1'b1;
    run("p5", 25);
    flash = 1'b0;
    run("p5", 20);

    // Plan 6: reset mid-operation with a pending request.
    demand = 4'b0001;
    do_reset("p6");
    ped = 4'b1000;
    cyc("p6");
    ped = '0;
    run("p6", 10);
    do_reset("p6r");
    chk("p6.bad_clear", 32'(bad_state_o), 32'(0));

    // Random traffic, buttons, flash and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) demand = N'($urandom);
      ped = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 149) == 0) flash = !flash;
      rst = ($urandom_range(0, 499) == 0);
      cyc("rnd");
    end
    rst = 1'b0;

    // Corrupt the state encoding: the flag latches and lamps fall back to all red.
    demand = '0; ped = '0; flash = 1'b0;
    do_reset("bs");
    run("bs", 3);
    force dut.r_state = intersection_state_t'(4'b0011);
    @(posedge clk);
    #1;
    release dut.r_state;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("bs.flag", 32'(bad_state_o), 32'(1));
      chk("bs.red", 32'(red_o), 32'(4'b1111));
      chk("bs.green", 32'(green_o), 32'(0));
    end
    model_reset();
    do_reset("bs_rst");
    chk("bs.cleared", 32'(bad_state_o), 32'(0));
    run("post", 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
